// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: DIV/DIVU sequencer in front of an unsigned multi-cycle divider; owns HI/LO.
// Optional WAIT watchdog enabled by defining DIV_SEQ_TIMEOUT_EN.
module div_seq_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid_i,
    input  logic        req_signed_i,
    input  logic [31:0] req_dividend_i,
    input  logic [31:0] req_divisor_i,
    output logic        busy_o,
    output logic        div_start_o,
    output logic [31:0] div_dividend_o,
    output logic [31:0] div_divisor_o,
    input  logic        div_done_i,
    input  logic [31:0] div_quotient_i,
    input  logic [31:0] div_remainder_i,
    input  logic        wr_hi_i,
    input  logic        wr_lo_i,
    input  logic [31:0] wr_data_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        div_by_zero_o,
    output logic        timeout_err_o
);
    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_ARM, S_WAIT, S_FIXUP, S_ZERO} state_e;
    state_e      state_q, state_d;
    logic        qneg_q, qneg_d, rneg_q, rneg_d;
    logic [31:0] a_q, a_d, dvd_q, dvd_d, dvs_q, dvs_d, hi_q, hi_d, lo_q, lo_d;
    logic        sa, sb, tmo;
    assign sa = req_signed_i & req_dividend_i[31];
    assign sb = req_signed_i & req_divisor_i[31];
`ifdef DIV_SEQ_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) cnt_q <= '0;
        else cnt_q <= (state_q == S_WAIT) ? cnt_q + 1'b1 : '0;
    assign tmo = (state_q == S_WAIT) && !div_done_i && (cnt_q == CNT_W'(TIMEOUT - 1));
`else
    logic unused_cfg;
    assign unused_cfg = ^{TIMEOUT, CNT_W};
    assign tmo = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        a_d     = a_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                hi_d = wr_hi_i ? wr_data_i : hi_q;
                lo_d = wr_lo_i ? wr_data_i : lo_q;
                if (req_valid_i) begin
                    qneg_d  = sa ^ sb;
                    rneg_d  = sa;
                    a_d     = req_dividend_i;
                    dvd_d   = sa ? -req_dividend_i : req_dividend_i;
                    dvs_d   = sb ? -req_divisor_i : req_divisor_i;
                    state_d = (req_divisor_i == '0) ? S_ZERO : S_LAUNCH;
                end
            end
            S_LAUNCH: state_d = S_ARM;
            // done may still be high from the previous division here
            S_ARM:    state_d = S_WAIT;
            S_WAIT:   state_d = div_done_i ? S_FIXUP : (tmo ? S_IDLE : S_WAIT);
            S_FIXUP: begin
                lo_d    = qneg_q ? -div_quotient_i : div_quotient_i;
                hi_d    = rneg_q ? -div_remainder_i : div_remainder_i;
                state_d = S_IDLE;
            end
            S_ZERO: begin
                lo_d    = '1;
                hi_d    = a_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state_q <= S_IDLE;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            a_q     <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            a_q     <= a_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    assign busy_o         = state_q != S_IDLE;
    assign div_start_o    = state_q == S_LAUNCH;
    assign div_dividend_o = dvd_q;
    assign div_divisor_o  = dvs_q;
    assign hi_o           = hi_q;
    assign lo_o           = lo_q;
    assign div_by_zero_o  = state_q == S_ZERO;
    assign timeout_err_o  = tmo;
endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: randomized and directed checks of div_seq_ctrl against a behavioural
// divider and an arithmetic reference model of DIV/DIVU results.
module tb_div_seq_ctrl;
    localparam int TIMEOUT = 64;
    logic        clk = 1'b0, reset_n = 1'b0;
    logic        req_valid = 0, req_signed = 0, wr_hi = 0, wr_lo = 0;
    logic [31:0] req_dividend = 0, req_divisor = 0, wr_data = 0;
    logic        busy, div_start, div_done, div_by_zero, timeout_err;
    logic [31:0] div_dividend, div_divisor, div_quotient, div_remainder, hi, lo;
    int          checks = 0, failures = 0;
    logic [31:0] exp_hi = 0, exp_lo = 0;
    // behavioural divider: done rises so that it is first sampled n_cyc+2 edges after start
    int          n_cyc = 4, cnt = 0;
    bit          stale = 0, never = 0, idle_done = 0;
    logic        done_r = 0;
    logic [31:0] m_q = 0, m_r = 0;

    div_seq_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid_i(req_valid), .req_signed_i(req_signed),
        .req_dividend_i(req_dividend), .req_divisor_i(req_divisor), .busy_o(busy),
        .div_start_o(div_start), .div_dividend_o(div_dividend), .div_divisor_o(div_divisor),
        .div_done_i(div_done), .div_quotient_i(div_quotient), .div_remainder_i(div_remainder),
        .wr_hi_i(wr_hi), .wr_lo_i(wr_lo), .wr_data_i(wr_data), .hi_o(hi), .lo_o(lo),
        .div_by_zero_o(div_by_zero), .timeout_err_o(timeout_err));

    always #5 clk = ~clk;
    assign div_done      = done_r | idle_done;
    assign div_quotient  = m_q;
    assign div_remainder = m_r;

    always @(posedge clk)
        if (div_start) begin
            cnt    <= never ? 0 : n_cyc + 1;
            done_r <= stale;
            m_q    <= (div_divisor != 0) ? div_dividend / div_divisor : 32'hDEADBEEF;
            m_r    <= (div_divisor != 0) ? div_dividend % div_divisor : 32'hDEADBEEF;
        end else if (cnt > 1) begin
            cnt    <= cnt - 1;
            done_r <= 1'b0;
        end else if (cnt == 1) begin
            cnt    <= 0;
            done_r <= 1'b1;
        end

    task automatic run_div(input bit sg, input logic [31:0] a, input logic [31:0] b,
                           input int n, input bit stl, input bit nev);
        longint sa, sb, q, r;
        logic [31:0] e_lo, e_hi, e_da, e_db, da, db;
        int busy_cnt, starts, dbz, tmo, e_busy;
        sa = sg ? longint'($signed(a)) : longint'(a);
        sb = sg ? longint'($signed(b)) : longint'(b);
        e_da = 32'(sa < 0 ? -sa : sa);
        e_db = 32'(sb < 0 ? -sb : sb);
        if (b == 0) begin
            e_lo = 32'hFFFFFFFF; e_hi = a; e_busy = 1;
        end else if (nev) begin
            e_lo = exp_lo; e_hi = exp_hi; e_busy = TIMEOUT + 2;
        end else begin
            q = sa / sb; r = sa % sb;
            e_lo = 32'(q); e_hi = 32'(r); e_busy = n + 4;
        end
        n_cyc = n; stale = stl; never = nev;
        @(negedge clk);
        req_valid = 1; req_signed = sg; req_dividend = a; req_divisor = b;
        @(negedge clk);
        req_valid = 0; req_dividend = $urandom; req_divisor = $urandom;
        busy_cnt = 0; starts = 0; dbz = 0; tmo = 0; da = 0; db = 0;
        while (busy && busy_cnt < 300) begin
            if (div_start) begin starts++; da = div_dividend; db = div_divisor; end
            dbz += int'(div_by_zero);
            tmo += int'(timeout_err);
            busy_cnt++;
            @(negedge clk);
        end
        checks++; if (busy_cnt !== e_busy) begin failures++; $display("FAIL busy_cycles a=%h b=%h: got %0d expected %0d", a, b, busy_cnt, e_busy); end
        checks++; if (starts !== int'(b != 0)) begin failures++; $display("FAIL start_pulses a=%h b=%h: got %0d expected %0d", a, b, starts, int'(b != 0)); end
        checks++; if (dbz !== int'(b == 0)) begin failures++; $display("FAIL div_by_zero a=%h b=%h: got %0d expected %0d", a, b, dbz, int'(b == 0)); end
        checks++; if (tmo !== int'(nev)) begin failures++; $display("FAIL timeout_err a=%h b=%h: got %0d expected %0d", a, b, tmo, int'(nev)); end
        checks++; if (lo !== e_lo) begin failures++; $display("FAIL lo sg=%0d a=%h b=%h: got %h expected %h", sg, a, b, lo, e_lo); end
        checks++; if (hi !== e_hi) begin failures++; $display("FAIL hi sg=%0d a=%h b=%h: got %h expected %h", sg, a, b, hi, e_hi); end
        if (b != 0) begin
            checks++; if ({da, db} !== {e_da, e_db}) begin failures++; $display("FAIL magnitudes a=%h b=%h: got %h/%h expected %h/%h", a, b, da, db, e_da, e_db); end
        end
        exp_lo = e_lo; exp_hi = e_hi;
        stale = 0; never = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if ({busy, div_start, div_by_zero, timeout_err} !== 4'b0) begin failures++; $display("FAIL reset_flags: got %b expected 0000", {busy, div_start, div_by_zero, timeout_err}); end
        checks++; if ({hi, lo, div_dividend, div_divisor} !== 128'b0) begin failures++; $display("FAIL reset_data: got %h %h %h %h expected zeros", hi, lo, div_dividend, div_divisor); end
        reset_n = 1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_div(0, 100, 7, 34, 0, 0);
        run_div(1, -32'sd7, 2, 5, 0, 0);
        run_div(1, 7, -32'sd2, 3, 0, 0);
        run_div(1, 32'h80000000, 32'hFFFFFFFF, 2, 0, 0);
        run_div(0, 32'hFFFFFFFF, 1, 1, 0, 0);
        run_div(0, 5, 0, 4, 0, 0);
        run_div(1, 32'hFFFFFFF0, 0, 4, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            logic [31:0] a, b;
            int sel;
            a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            sel = $urandom_range(0, 3);
            b = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(1, 15)) : $urandom;
            if (sel == 1 && $urandom_range(0, 1) == 1) b = -b;
            run_div(1'($urandom_range(0, 1)), a, b, $urandom_range(1, 10), 0, 0);
        end
    endtask

    task automatic test_mthi_mtlo();
        int k;
        @(negedge clk); wr_hi = 1; wr_data = 32'h1234;
        @(negedge clk); wr_hi = 0; exp_hi = 32'h1234;
        checks++; if (hi !== exp_hi) begin failures++; $display("FAIL mthi_idle: got %h expected %h", hi, exp_hi); end
        n_cyc = 4;
        wr_lo = 1; wr_data = 32'hAA; req_valid = 1; req_signed = 0; req_dividend = 9; req_divisor = 3;
        @(negedge clk); wr_lo = 0; req_valid = 0;
        checks++; if (lo !== 32'hAA) begin failures++; $display("FAIL mtlo_same_edge: got %h expected %h", lo, 32'hAA); end
        @(negedge clk); wr_hi = 1; wr_data = 32'h5555;
        @(negedge clk); wr_hi = 0;
        checks++; if (hi !== exp_hi) begin failures++; $display("FAIL mthi_busy_dropped: got %h expected %h", hi, exp_hi); end
        k = 0;
        while (busy && k < 100) begin k++; @(negedge clk); end
        checks++; if ({hi, lo} !== {32'd0, 32'd3}) begin failures++; $display("FAIL mt_result: got %h/%h expected 0/3", hi, lo); end
        exp_hi = 0; exp_lo = 3;
    endtask

    task automatic test_stale_done();
        idle_done = 1;
        repeat (3) @(negedge clk);
        checks++; if ({busy, lo} !== {1'b0, exp_lo}) begin failures++; $display("FAIL idle_done_ignored: got %b/%h expected 0/%h", busy, lo, exp_lo); end
        idle_done = 0;
        run_div(0, 1000, 10, 6, 1, 0);
        run_div(1, -32'sd1000, 7, 9, 1, 0);
    endtask

    task automatic test_async_reset();
        n_cyc = 30;
        @(negedge clk); req_valid = 1; req_signed = 0; req_dividend = 100; req_divisor = 7;
        @(negedge clk); req_valid = 0;
        repeat (6) @(negedge clk);
        #2 reset_n = 0;
        #1;
        checks++; if ({busy, div_start, div_by_zero, timeout_err} !== 4'b0) begin failures++; $display("FAIL async_reset_flags: got %b expected 0000", {busy, div_start, div_by_zero, timeout_err}); end
        checks++; if ({hi, lo, div_dividend, div_divisor} !== 128'b0) begin failures++; $display("FAIL async_reset_data: got %h %h %h %h expected zeros", hi, lo, div_dividend, div_divisor); end
        exp_hi = 0; exp_lo = 0;
        @(negedge clk); reset_n = 1;
        run_div(0, 8, 2, 3, 0, 0);
    endtask

`ifdef DIV_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        run_div(0, 50, 5, 0, 0, 1);
        run_div(0, 50, 5, 3, 0, 0);
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_mthi_mtlo();
        test_stale_done();
        test_random();
        test_async_reset();
`ifdef DIV_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
